// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_state_t   FSM state encoding (IDLE, WAIT, DONE)
//   F3_*          funct3 access size/sign codes
//   TIMEOUT_DEF   default WAIT cycles allowed before a memory access aborts
//   lsu_illegal   misaligned / unsupported access detection
//   lsu_store_be  byte enables for a store
//   lsu_store_wd  lane-replicated store data
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 16;

  function automatic logic lsu_illegal(input logic [2:0] f3, input logic [1:0] off,
                                       input logic rd, input logic wr);
    logic bad;
    bad = rd & wr;
    case (f3)
      F3_B, F3_BU: bad = bad;
      F3_H, F3_HU: bad = bad | off[0];
      F3_W:        bad = bad | (|off);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Size comes from funct3[1:0]; the sign bit is meaningless for stores.
  function automatic logic [3:0] lsu_store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_store_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half out of a memory word and extends it.
//   word    in  32  raw memory read data
//   offset  in  2   byte offset within the word
//   funct3  in  3   access size/sign
//   data    out 32  formatted load result
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data memory interface with a three-state handshake FSM.
//   clk, rst_n               clock, async active-low reset
//   valid_in, MemRead_in,
//   MemWrite_in, funct3_in,
//   addr_in, wdata_in        access from the EX/MEM register
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata        registered memory request, held stable during WAIT
//   mem_rdata, mem_ack       memory response (only observed in WAIT)
//   stall                    freezes upstream pipeline while an access is in flight
//   rdata_out                formatted load data, held between load completions
//   access_err               one-cycle pulse on illegal or timed-out access
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        access_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] ld_data;
  logic        access, illegal, legal;

  assign access  = valid_in & (MemRead_in | MemWrite_in);
  assign illegal = access & lsu_illegal(funct3_in, addr_in[1:0], MemRead_in, MemWrite_in);
  assign legal   = access & ~illegal;

  // Stall is combinational so the accepting IDLE cycle already freezes the pipe.
  assign stall = ((state == ST_IDLE) & legal) | (state == ST_WAIT);

  load_align u_align (
    .word   (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      rdata_out  <= '0;
      access_err <= 1'b0;
    end else begin
      access_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (illegal) begin
            access_err <= 1'b1;
          end else if (legal) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            off_q     <= addr_in[1:0];
            f3_q      <= funct3_in;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite_in;
            mem_addr  <= {addr_in[7:2], 2'b00};
            mem_be    <= MemWrite_in ? lsu_store_be(funct3_in, addr_in[1:0]) : 4'b1111;
            mem_wdata <= MemWrite_in ? lsu_store_wd(funct3_in, wdata_in) : 32'd0;
          end
        end
        ST_WAIT: begin
          // mem_we still holds the access direction here; it is cleared with mem_req.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) rdata_out <= ld_data;
            state   <= ST_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            access_err <= 1'b1;
            if (!mem_we) rdata_out <= '0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic [2:0]  funct3_in = 3'b0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic [31:0] rdata_out;
  logic        access_err;

  int total = 0;
  int bad = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .funct3_in(funct3_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .rdata_out(rdata_out), .access_err(access_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_in = v; MemRead_in = rd; MemWrite_in = wr;
    funct3_in = f3; addr_in = a; wdata_in = wd;
  endtask

  // Legal access: ack arrives on WAIT cycle ack_at (0-based); ack_at >= TO means never.
  task automatic xfer(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                      input logic [31:0] mrd, input logic [7:0] e_addr, input logic [3:0] e_be,
                      input logic [31:0] e_wd, input logic [31:0] e_rdata, input bit e_err);
    int req_cycles;
    int exp_cycles;
    req_cycles = 0;
    exp_cycles = (ack_at < TO) ? ack_at + 1 : TO;
    @(posedge clk); #1;
    drive(1'b1, rd, wr, f3, a, wd); #1;
    chk({tag, "/idle_stall"}, 32'(stall), 32'd1);
    chk({tag, "/idle_req"}, 32'(mem_req), 32'd0);
    for (int i = 0; i < TO; i++) begin
      @(posedge clk); #1;
      mem_ack = (i == ack_at);
      mem_rdata = (i == ack_at) ? mrd : 32'h5A5A_5A5A;
      #1;
      if (mem_req) req_cycles++;
      if (i == 0) begin
        chk({tag, "/stall_wait"}, 32'(stall), 32'd1);
        chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(e_addr));
        chk({tag, "/mem_be"}, 32'(mem_be), 32'(e_be));
        chk({tag, "/mem_wdata"}, mem_wdata, e_wd);
        chk({tag, "/mem_we"}, 32'(mem_we), 32'(wr));
      end
      if (i == ack_at) break;
    end
    chk({tag, "/req_cycles"}, 32'(req_cycles), 32'(exp_cycles));
    @(posedge clk); #1;
    mem_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b0, '0, '0); #1;
    chk({tag, "/done_stall"}, 32'(stall), 32'd0);
    chk({tag, "/done_req"}, 32'(mem_req), 32'd0);
    chk({tag, "/done_err"}, 32'(access_err), 32'(e_err));
    chk({tag, "/rdata"}, rdata_out, e_rdata);
    @(posedge clk); #2;
    chk({tag, "/err_pulse_end"}, 32'(access_err), 32'd0);
    chk({tag, "/rdata_hold"}, rdata_out, e_rdata);
  endtask

  task automatic illegal(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] e_rdata);
    @(posedge clk); #1;
    drive(1'b1, rd, wr, f3, a, 32'h1111_2222); #1;
    chk({tag, "/stall"}, 32'(stall), 32'd0);
    chk({tag, "/req"}, 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b0, '0, '0); #1;
    chk({tag, "/err"}, 32'(access_err), 32'd1);
    chk({tag, "/req_after"}, 32'(mem_req), 32'd0);
    chk({tag, "/rdata"}, rdata_out, e_rdata);
    @(posedge clk); #2;
    chk({tag, "/err_end"}, 32'(access_err), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst/state_req", 32'(mem_req), 32'd0);
    chk("rst/we", 32'(mem_we), 32'd0);
    chk("rst/be", 32'(mem_be), 32'd0);
    chk("rst/addr", 32'(mem_addr), 32'd0);
    chk("rst/wdata", mem_wdata, 32'd0);
    chk("rst/rdata", rdata_out, 32'd0);
    chk("rst/err", 32'(access_err), 32'd0);
    chk("rst/stall", 32'(stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    xfer("lw10",  1, 0, 3'b010, 32'h10, 0, 0, 32'hDEAD_BEEF, 8'h10, 4'hF, 0, 32'hDEAD_BEEF, 0);
    xfer("lb13",  1, 0, 3'b000, 32'h13, 0, 2, 32'h8012_3456, 8'h10, 4'hF, 0, 32'hFFFF_FF80, 0);
    xfer("lbu13", 1, 0, 3'b100, 32'h13, 0, 1, 32'h8012_3456, 8'h10, 4'hF, 0, 32'h0000_0080, 0);
    xfer("sh22",  0, 1, 3'b001, 32'h22, 32'h0000_ABCD, 0, 32'hFFFF_FFFF, 8'h20, 4'b1100,
         32'hABCD_ABCD, 32'h0000_0080, 0);
    xfer("sb41",  0, 1, 3'b000, 32'h41, 32'h1234_56EF, 3, 0, 8'h40, 4'b0010,
         32'hEFEF_EFEF, 32'h0000_0080, 0);
    xfer("lh06",  1, 0, 3'b001, 32'h06, 0, 0, 32'h8001_7FFF, 8'h04, 4'hF, 0, 32'hFFFF_8001, 0);
    xfer("lhu06", 1, 0, 3'b101, 32'h06, 0, 0, 32'h8001_7FFF, 8'h04, 4'hF, 0, 32'h0000_8001, 0);
    xfer("sw1fc", 0, 1, 3'b010, 32'h1FC, 32'hCAFE_F00D, 0, 0, 8'hFC, 4'hF,
         32'hCAFE_F00D, 32'h0000_8001, 0);

    illegal("ill_lw05", 1, 0, 3'b010, 32'h05, 32'h0000_8001);
    illegal("ill_lh03", 1, 0, 3'b001, 32'h03, 32'h0000_8001);
    illegal("ill_f3_011", 1, 0, 3'b011, 32'h00, 32'h0000_8001);
    illegal("ill_rdwr", 1, 1, 3'b010, 32'h00, 32'h0000_8001);

    // Reset during the third WAIT cycle of a load; a late ack must be ignored.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h50, 0);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    chk("rstwait/req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b0, '0, '0); #1;
    chk("rstwait/req", 32'(mem_req), 32'd0);
    chk("rstwait/stall", 32'(stall), 32'd0);
    chk("rstwait/rdata", rdata_out, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    mem_ack = 1'b0; #1;
    chk("rstwait/late_ack_rdata", rdata_out, 32'd0);
    chk("rstwait/late_ack_err", 32'(access_err), 32'd0);
    chk("rstwait/late_ack_req", 32'(mem_req), 32'd0);

    // Give rdata_out a nonzero value, then let a load time out.
    xfer("lw_pre", 1, 0, 3'b010, 32'h34, 0, 0, 32'h0BAD_F00D, 8'h34, 4'hF, 0, 32'h0BAD_F00D, 0);
    xfer("lw_to",  1, 0, 3'b010, 32'h30, 0, 99, 0, 8'h30, 4'hF, 0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
